// File: rtl/featuremap_pad_writer_if.sv
// Pixel-stream and channel-FIFO signals of one featuremap_pad_writer instance.
// slave is the writer's view; master is the source/FIFO/controller side.
interface featuremap_pad_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_in;
    logic                  fifo_full;
    logic                  wrreq;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  frame_done;

    modport slave (
        input  start, valid_in, data_in, fifo_full,
        output ready_in, wrreq, data_out, busy, frame_done
    );

    modport master (
        output start, valid_in, data_in, fifo_full,
        input  ready_in, wrreq, data_out, busy, frame_done
    );
endinterface

// File: rtl/featuremap_pad_writer.sv
// Wraps a WIDTH x HEIGHT pixel raster in a one-word PAD_VALUE border and streams
// the padded raster, in raster order, into a conv2D channel FIFO.
module featuremap_pad_writer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WIDTH      = 112,
    parameter int                    HEIGHT     = 112,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   rst,
    featuremap_pad_writer_if.slave bus
);

    //  state    | meaning
    //  S_IDLE   | waiting for start
    //  S_TOP    | pad row 0, WIDTH+2 words
    //  S_LEFT   | left border word of a pixel row
    //  S_PIXEL  | WIDTH pass-through pixels
    //  S_RIGHT  | right border word of a pixel row
    //  S_BOTTOM | pad row HEIGHT+1, WIDTH+2 words
    //  S_DONE   | one cycle, frame_done high
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TOP    = 3'd1;
    localparam logic [2:0] S_LEFT   = 3'd2;
    localparam logic [2:0] S_PIXEL  = 3'd3;
    localparam logic [2:0] S_RIGHT  = 3'd4;
    localparam logic [2:0] S_BOTTOM = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 2);

    localparam logic [CW-1:0] COL_ROW_END = CW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_PIX_END = CW'(WIDTH);
    localparam logic [CW-1:0] COL_ONE     = CW'(1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(HEIGHT);
    localparam logic [RW-1:0] ROW_ONE     = RW'(1);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  frame_done_q, frame_done_d;
    logic                  wr;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] dout;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wr      = 1'b0;
        rdy     = 1'b0;
        dout    = PAD_VALUE;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_TOP;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_TOP, S_BOTTOM: begin
                wr = !bus.fifo_full;
                if (wr) begin
                    if (col_q == COL_ROW_END) begin
                        col_d = '0;
                        if (state_q == S_TOP) begin
                            state_d = S_LEFT;
                            row_d   = ROW_ONE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end
            end
            S_LEFT: begin
                wr = !bus.fifo_full;
                if (wr) begin
                    col_d   = col_q + COL_ONE;
                    state_d = S_PIXEL;
                end
            end
            S_PIXEL: begin
                // A stalled FIFO also stalls the source, so no pixel is dropped.
                rdy  = !bus.fifo_full;
                wr   = bus.valid_in && !bus.fifo_full;
                dout = bus.data_in;
                if (wr) begin
                    col_d = col_q + COL_ONE;
                    if (col_q == COL_PIX_END) begin
                        state_d = S_RIGHT;
                    end
                end
            end
            S_RIGHT: begin
                wr = !bus.fifo_full;
                if (wr) begin
                    col_d   = '0;
                    row_d   = row_q + ROW_ONE;
                    state_d = (row_q < ROW_LAST) ? S_LEFT : S_BOTTOM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.wrreq      = wr;
    assign bus.ready_in   = rdy;
    assign bus.data_out   = dout;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Scoreboard bench: a 4x3 instance under random pixels, backpressure, source gaps,
// mid-frame reset and stray starts, plus a 1x1 instance for the minimum frame.
module tb_featuremap_pad_writer;
    localparam int             DW  = 32;
    localparam logic [DW-1:0]  PAD = 32'h0000_0000;
    localparam int             W   = 4;
    localparam int             H   = 3;
    localparam int             LIM = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    featuremap_pad_writer_if #(.DATA_WIDTH(DW)) a_if ();
    featuremap_pad_writer_if #(.DATA_WIDTH(DW)) b_if ();

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .PAD_VALUE(PAD))
        dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(1), .HEIGHT(1), .PAD_VALUE(PAD))
        dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] src_a[$];
    int            gap_cfg = 0;
    bit            bp_en = 1'b0;
    int            accepted_a = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: padded raster built directly from the border rule.
    task automatic gen_frame_a();
        logic [DW-1:0] pix [W*H];
        for (int i = 0; i < W*H; i++) begin
            pix[i] = $urandom;
            src_a.push_back(pix[i]);
        end
        for (int r = 0; r < H+2; r++) begin
            for (int c = 0; c < W+2; c++) begin
                if (r == 0 || r == H+1 || c == 0 || c == W+1) exp_a.push_back(PAD);
                else exp_a.push_back(pix[(r-1)*W + (c-1)]);
            end
        end
    endtask

    // Source for instance a: holds valid_in until accepted, then idles gap_cfg cycles.
    initial begin : src_drv
        bit acc;
        int gap_left;
        gap_left = 0;
        a_if.valid_in = 1'b0;
        a_if.data_in  = '0;
        forever begin
            @(negedge clk);
            acc = a_if.valid_in && a_if.ready_in;
            @(posedge clk);
            #1;
            if (!rst) begin
                src_a.delete();
                a_if.valid_in = 1'b0;
                gap_left = 0;
            end else begin
                if (acc) begin
                    void'(src_a.pop_front());
                    accepted_a++;
                    a_if.valid_in = 1'b0;
                    gap_left = gap_cfg;
                end else if (!a_if.valid_in && gap_left > 0) begin
                    gap_left--;
                end
                if (!a_if.valid_in && gap_left == 0 && src_a.size() > 0) begin
                    a_if.valid_in = 1'b1;
                    a_if.data_in  = src_a[0];
                end
            end
        end
    end

    initial begin : bp_drv
        a_if.fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            a_if.fifo_full = bp_en && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every write is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (a_if.fifo_full) begin
                check("full_blocks_wrreq", 64'(a_if.wrreq), 64'd0);
                check("full_blocks_ready", 64'(a_if.ready_in), 64'd0);
            end
            if (a_if.wrreq) begin
                if (exp_a.size() == 0) check("a_write_expected", 64'(exp_a.size()), 64'd1);
                else check("a_word", 64'(a_if.data_out), 64'(exp_a.pop_front()));
            end
            if (b_if.wrreq) begin
                if (exp_b.size() == 0) check("b_write_expected", 64'(exp_b.size()), 64'd1);
                else check("b_word", 64'(b_if.data_out), 64'(exp_b.pop_front()));
            end
        end
    end

    // mode 0: plain frame, 1: stray starts mid-frame and in DONE, 2: reset after 15 writes
    task automatic run_frame_a(input int gap, input bit bp, input int mode);
        int k, rdy, cyc, last, acc0;
        gap_cfg = gap;
        bp_en   = bp;
        acc0    = accepted_a;
        gen_frame_a();
        @(posedge clk); #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
        k = 0; rdy = 0; cyc = 0; last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (a_if.wrreq) begin
                k++;
                last = cyc;
            end
            if (a_if.ready_in) rdy++;
            if (cyc == 1 && !bp) check("start_latency_wrreq", 64'(a_if.wrreq), 64'd1);
            if (mode == 2 && k == 15) begin
                #1 rst = 1'b0;
                #1;
                check("rst_wrreq", 64'(a_if.wrreq), 64'd0);
                check("rst_busy", 64'(a_if.busy), 64'd0);
                check("rst_ready_in", 64'(a_if.ready_in), 64'd0);
                check("rst_data_out", 64'(a_if.data_out), 64'(PAD));
                exp_a.delete();
                bp_en = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("post_rst_idle_wrreq", 64'(a_if.wrreq), 64'd0);
                    check("post_rst_idle_busy", 64'(a_if.busy), 64'd0);
                end
                return;
            end
            if (a_if.frame_done) break;
            if (cyc > LIM) begin
                check("frame_done_timeout", 64'(a_if.frame_done), 64'd1);
                break;
            end
            @(posedge clk);
            #1 a_if.start = (mode == 1) && (k == 10 || k == 30);
        end
        check("done_busy_high", 64'(a_if.busy), 64'd1);
        check("done_after_last_write", 64'(cyc - last), 64'd1);
        check("writes_per_frame", 64'(k), 64'd30);
        check("scoreboard_drained", 64'(exp_a.size()), 64'd0);
        check("pixels_consumed", 64'(accepted_a - acc0), 64'd12);
        if (!bp && gap == 0) begin
            check("done_cycle", 64'(cyc), 64'd31);
            check("ready_cycles", 64'(rdy), 64'd12);
        end
        @(posedge clk); #1 a_if.start = 1'b0;
        @(negedge clk);
        check("busy_fall", 64'(a_if.busy), 64'd0);
        check("frame_done_single", 64'(a_if.frame_done), 64'd0);
        check("idle_wrreq", 64'(a_if.wrreq), 64'd0);
        bp_en = 1'b0;
    endtask

    task automatic run_b();
        logic [DW-1:0] p;
        int kb, rdyb, cyc;
        bit acc;
        p = $urandom;
        for (int i = 0; i < 9; i++) exp_b.push_back((i == 4) ? p : PAD);
        @(posedge clk);
        #1;
        b_if.valid_in = 1'b1;
        b_if.data_in  = p;
        b_if.start    = 1'b1;
        @(posedge clk); #1 b_if.start = 1'b0;
        kb = 0; rdyb = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (b_if.wrreq) kb++;
            if (b_if.ready_in) rdyb++;
            acc = b_if.valid_in && b_if.ready_in;
            if (b_if.frame_done) break;
            if (cyc > LIM) begin
                check("b_frame_done_timeout", 64'(b_if.frame_done), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            if (acc) b_if.valid_in = 1'b0;
        end
        check("b_writes", 64'(kb), 64'd9);
        check("b_ready_cycles", 64'(rdyb), 64'd1);
        check("b_done_cycle", 64'(cyc), 64'd10);
        check("b_scoreboard_drained", 64'(exp_b.size()), 64'd0);
        @(negedge clk);
        check("b_busy_fall", 64'(b_if.busy), 64'd0);
    endtask

    initial begin
        a_if.start    = 1'b0;
        b_if.start    = 1'b0;
        b_if.valid_in = 1'b0;
        b_if.data_in  = '0;
        b_if.fifo_full = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_wrreq", 64'(a_if.wrreq), 64'd0);
        check("reset_ready_in", 64'(a_if.ready_in), 64'd0);
        check("reset_busy", 64'(a_if.busy), 64'd0);
        check("reset_frame_done", 64'(a_if.frame_done), 64'd0);
        check("reset_data_out", 64'(a_if.data_out), 64'(PAD));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_b();
        run_frame_a(0, 1'b0, 0);
        run_frame_a(0, 1'b1, 0);
        run_frame_a(2, 1'b0, 0);
        run_frame_a(0, 1'b0, 2);
        run_frame_a(0, 1'b0, 0);
        run_frame_a(0, 1'b0, 1);
        run_frame_a(0, 1'b0, 0);
        run_frame_a(1, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
